digital_lock_ctrl: RTL and testbench



---
 rtl/digital_lock_ctrl.sv | 117 +++++++++++
 tb/tb_digital_lock_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/digital_lock_ctrl.sv
// Keypad door lock: X,Y,X,X,Y opens the strike; the FSM advances on a divided tick.
// Define DIGITAL_LOCK_DEBUG_EN to drive the live state/next-state codes on oCSTATE/oNSTATE.
module digital_lock_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int OPEN_TICKS = 8
) (
  input  logic       iCLK,
  input  logic       iRESET,
  input  logic       iX,
  input  logic       iY,
  input  logic       iLOCK,
  output logic       oUNLOCK,
  output logic       oGREEN,
  output logic [3:0] oCSTATE,
  output logic [3:0] oNSTATE,
  output logic       oclk_div
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int OW  = (OPEN_TICKS > 1) ? $clog2(OPEN_TICKS) : 1;

  if (TICK_HZ <= 0 || CLK_HZ % TICK_HZ != 0 || DIV < 2 || DIV % 2 != 0) begin : g_bad_div
    $error("digital_lock_ctrl: CLK_HZ/TICK_HZ must be an even integer >= 2");
  end
  if (OPEN_TICKS < 1) begin : g_bad_open
    $error("digital_lock_ctrl: OPEN_TICKS must be >= 1");
  end

  typedef enum logic [3:0] {
    S_IDLE     = 4'b0000,
    S_GOT_X    = 4'b0001,
    S_GOT_XY   = 4'b0010,
    S_GOT_XYX  = 4'b0011,
    S_GOT_XYXX = 4'b0100,
    S_OPEN     = 4'b0101,
    S_ERROR    = 4'b1000
  } state_e;

  logic [CW-1:0] cnt_q;
  logic          clk_div_q;
  logic          tick;
  state_e        state_q, state_d;
  logic          x_prev_q, y_prev_q;
  logic [OW-1:0] open_cnt_q;
  logic          unlock_q, green_q;
  logic          px, py, one_x, one_y, open_done;

  // tick coincides with the 1->0 edge of the divided clock
  assign tick = (cnt_q == CW'(DIV - 1));

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      cnt_q     <= '0;
      clk_div_q <= 1'b0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
      if (cnt_q == CW'(DIV / 2 - 1) || tick)
        clk_div_q <= ~clk_div_q;
    end
  end

  assign px        = iX & ~x_prev_q;
  assign py        = iY & ~y_prev_q;
  assign one_x     = px & ~py;
  assign one_y     = py & ~px;
  assign open_done = (open_cnt_q == OW'(OPEN_TICKS - 1));

  always_comb begin
    state_d = state_q;
    if (iLOCK) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     if (px | py) state_d = one_x ? S_GOT_X    : S_ERROR;
        S_GOT_X:    if (px | py) state_d = one_y ? S_GOT_XY   : S_ERROR;
        S_GOT_XY:   if (px | py) state_d = one_x ? S_GOT_XYX  : S_ERROR;
        S_GOT_XYX:  if (px | py) state_d = one_x ? S_GOT_XYXX : S_ERROR;
        S_GOT_XYXX: if (px | py) state_d = one_y ? S_OPEN     : S_ERROR;
        S_OPEN:     if (open_done) state_d = S_IDLE;
        S_ERROR:    state_d = S_ERROR;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q    <= S_IDLE;
      x_prev_q   <= 1'b0;
      y_prev_q   <= 1'b0;
      open_cnt_q <= '0;
      unlock_q   <= 1'b0;
      green_q    <= 1'b0;
    end else if (tick) begin
      state_q    <= state_d;
      x_prev_q   <= iX;
      y_prev_q   <= iY;
      open_cnt_q <= (state_q == S_OPEN && state_d == S_OPEN) ? open_cnt_q + OW'(1) : '0;
      unlock_q   <= (state_d == S_OPEN) && (state_q != S_OPEN);
      green_q    <= (state_d == S_OPEN);
    end
  end

  assign oUNLOCK  = unlock_q;
  assign oGREEN   = green_q;
  assign oclk_div = clk_div_q;

`ifdef DIGITAL_LOCK_DEBUG_EN
  assign oCSTATE = state_q;
  assign oNSTATE = state_d;
`else
  assign oCSTATE = 4'b0000;
  assign oNSTATE = 4'b0000;
`endif

endmodule

// File: tb/tb_digital_lock_ctrl.sv
// Directed + randomized bench for digital_lock_ctrl with a sequence-progress reference model.
`timescale 1ns/100ps
module tb_digital_lock_ctrl;
  localparam int CLK_HZ = 2, TICK_HZ = 1, OPEN_TICKS = 1;
`ifdef DIGITAL_LOCK_DEBUG_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  logic       iCLK = 1'b0, iRESET = 1'b1, iX = 1'b0, iY = 1'b0, iLOCK = 1'b0;
  logic       oUNLOCK, oGREEN, oclk_div;
  logic [3:0] oCSTATE, oNSTATE;

  int checks = 0, failures = 0;

  // model: how many code presses matched so far (5 = open), error flag, ticks spent open
  int prog = 0, ocnt = 0;
  bit err = 0, m_xp = 0, m_yp = 0, m_green = 0, m_unlock = 0;
  bit code_y [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  digital_lock_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .OPEN_TICKS(OPEN_TICKS)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iX(iX), .iY(iY), .iLOCK(iLOCK),
    .oUNLOCK(oUNLOCK), .oGREEN(oGREEN), .oCSTATE(oCSTATE), .oNSTATE(oNSTATE),
    .oclk_div(oclk_div)
  );

  always #2.5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [3:0] enc(input int p, input bit e);
    logic [3:0] c;
    c = e ? 4'b1000 : 4'(p);
    return DBG ? c : 4'b0000;
  endfunction

  task automatic model_eval(input bit x, input bit y, input bit lk,
                            output int np, output bit ne, output int no);
    bit px, py;
    px = x & !m_xp;
    py = y & !m_yp;
    np = prog; ne = err; no = ocnt;
    if (lk) begin
      np = 0; ne = 0; no = 0;
    end else if (err) begin
    end else if (prog == 5) begin
      no = ocnt + 1;
      if (no >= OPEN_TICKS) begin np = 0; no = 0; end
    end else if (px && py) begin
      ne = 1;
    end else if (px || py) begin
      if (py == code_y[prog]) begin
        np = prog + 1;
        no = 0;
      end else ne = 1;
    end
  endtask

  // Entered and left at posedge+1; spans one full tick period (2 iCLK cycles).
  task automatic tick(input bit x, input bit y, input bit lk);
    int np, no;
    bit ne;
    @(negedge iCLK);
    iX = x; iY = y; iLOCK = lk;
    @(posedge iCLK); #1;
    chk("clkdiv_hi", 4'(oclk_div), 4'h1);
    model_eval(x, y, lk, np, ne, no);
    chk("nstate", oNSTATE, enc(np, ne));
    @(posedge iCLK); #1;
    m_unlock = (np == 5) && !ne && (prog != 5);
    m_green  = (np == 5) && !ne;
    prog = np; err = ne; ocnt = no; m_xp = x; m_yp = y;
    chk("clkdiv_lo", 4'(oclk_div), 4'h0);
    chk("cstate", oCSTATE, enc(prog, err));
    chk("green", 4'(oGREEN), 4'(m_green));
    chk("unlock", 4'(oUNLOCK), 4'(m_unlock));
  endtask

  task automatic do_reset(input int cycles);
    iRESET = 1'b1; iX = 0; iY = 0; iLOCK = 0;
    repeat (cycles) @(posedge iCLK);
    #1;
    prog = 0; err = 0; ocnt = 0; m_xp = 0; m_yp = 0; m_green = 0; m_unlock = 0;
    chk("rst_clkdiv", 4'(oclk_div), 4'h0);
    chk("rst_cstate", oCSTATE, 4'h0);
    chk("rst_unlock", 4'(oUNLOCK), 4'h0);
    chk("rst_green", 4'(oGREEN), 4'h0);
    iRESET = 1'b0;
  endtask

  task automatic press(input bit y);
    tick(!y, y, 0);
    tick(0, 0, 0);
  endtask

  task automatic send_code();
    for (int i = 0; i < 5; i++) press(code_y[i]);
  endtask

  initial begin
    do_reset(2);

    // correct code; last Y held across OPEN and back into IDLE
    press(0); press(1); press(0); press(0);
    tick(0, 1, 0);
    chk("open_green", 4'(oGREEN), 4'h1);
    chk("open_unlock", 4'(oUNLOCK), 4'h1);
    tick(0, 1, 0);
    chk("relock_green", 4'(oGREEN), 4'h0);
    tick(0, 1, 0);
    tick(0, 0, 0);

    // wrong code X,Y,Y then extra X, then lock
    press(0); press(1); press(1);
    chk("err_flag", 4'(err), 4'h1);
    press(0);
    tick(0, 0, 1);
    send_code();

    // lock mid-sequence
    press(0); press(1);
    tick(0, 0, 1);
    send_code();

    // both buttons together from IDLE, then while OPEN
    tick(1, 1, 0); tick(0, 0, 0);
    tick(0, 0, 1);
    press(0); press(1); press(0); press(0);
    tick(0, 1, 0);
    tick(1, 1, 0);
    chk("open_xy_noerr", 4'(err), 4'h0);
    tick(0, 0, 0);

    // reset mid-sequence
    press(0); press(1);
    chk("pre_rst_prog", 4'(prog), 4'h2);
    do_reset(1);
    send_code();

    // randomized traffic mixed with genuine codes
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        tick(0, 0, 1);
        send_code();
      end else begin
        for (int k = 0; k < 6; k++)
          tick($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
